// File: rtl/btn_conditioner.sv
// btn_conditioner
// Multi-channel push-button conditioner. Each raw button is synchronised
// into clk, debounced against a shared millisecond time base and turned
// into a clean level plus single-cycle press, release and long-press events.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   turbosim     1 = use TURBO_CLKS as tick period (short simulations)
//   btn_raw      raw bouncing buttons, 1 = pressed
//   btn_level    debounced level
//   btn_press    1-cycle pulse on a debounced 0->1 change
//   btn_release  1-cycle pulse on a debounced 1->0 change
//   btn_long     1-cycle pulse when a hold reaches LONG_MS ticks
//   btn_held     high from btn_long until the debounced release
//   tick         time-base strobe, exported for neighbouring timers
module btn_conditioner #(
  parameter int NBTN       = 2,
  parameter int CLK_PER_MS = 100000,
  parameter int TURBO_CLKS = 10,
  parameter int DEB_MS     = 20,
  parameter int LONG_MS    = 1000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            turbosim,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_long,
  output logic [NBTN-1:0] btn_held,
  output logic            tick
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int DW = $clog2(DEB_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);

  logic [PW-1:0] pre;
  logic [31:0]   term_m1;

  // A >= compare rather than == so that switching to the short turbo
  // period mid-count wraps at once instead of running to the long limit.
  assign term_m1 = turbosim ? 32'(TURBO_CLKS - 1) : 32'(CLK_PER_MS - 1);
  assign tick    = (32'(pre) >= term_m1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    logic          sync1;
    logic          s;
    logic          stable;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          press_q;
    logic          rel_q;
    logic          long_q;
    logic          held_q;
    logic          accept;
    logic          rel_now;
    logic          long_now;

    // The tick on which the disagreement count reaches DEB_MS accepts the
    // synchronised value as the new debounced level.
    assign accept   = tick && (s != stable) && (deb_cnt == DW'(DEB_MS - 1));
    assign rel_now  = accept && !s;
    // A long press cannot be reported on the very edge that releases.
    assign long_now = tick && stable && (hold_cnt == HW'(LONG_MS - 1)) && !rel_now;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1 <= 1'b0;
        s     <= 1'b0;
      end else begin
        sync1 <= btn_raw[i];
        s     <= sync1;
      end
    end

    // Any cycle of agreement clears the count, so bounce shorter than
    // DEB_MS ticks never reaches acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_cnt <= '0;
        stable  <= 1'b0;
      end else if (s == stable) begin
        deb_cnt <= '0;
      end else if (accept) begin
        deb_cnt <= '0;
        stable  <= s;
      end else if (tick) begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end

    // Hold counter saturates so the long event fires only once per press.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_cnt <= '0;
      end else if (!stable) begin
        hold_cnt <= '0;
      end else if (tick && (hold_cnt != HW'(LONG_MS))) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end

    // Events are registered alongside the level so each pulse coincides
    // with the first cycle the new level is visible.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        press_q <= accept && s;
        rel_q   <= rel_now;
        long_q  <= long_now;
        if (rel_now) begin
          held_q <= 1'b0;
        end else if (long_now) begin
          held_q <= 1'b1;
        end
      end
    end

    assign btn_level[i]   = stable;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_long[i]    = long_q;
    assign btn_held[i]    = held_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
// Scoreboard bench for btn_conditioner with turbosim time base
// (T = 10 cycles, DEB_MS = 4, LONG_MS = 8). Expected press/release/long
// events are queued with an acceptance window when stimulus is applied
// and popped by the monitor when the design pulses.
module tb_btn_conditioner;

  localparam int KPRESS = 1;
  localparam int KREL   = 2;
  localparam int KLONG  = 3;

  typedef struct {
    int kind;
    int ch;
    int lo;
    int hi;
    bit rel;
  } exp_event_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       turbosim;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;
  logic [1:0] btn_held;
  logic       tick;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  exp_event_t  sb[$];
  logic [1:0]  exp_level;
  int          last_press[2];
  logic [1:0]  prev_held     = 2'b00;
  logic [1:0]  rel_prev_held = 2'b00;

  btn_conditioner #(
    .NBTN(2), .CLK_PER_MS(100000), .TURBO_CLKS(10), .DEB_MS(4), .LONG_MS(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .turbosim(turbosim), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_held(btn_held), .tick(tick)
  );

  // 100 MHz clock and a cycle counter used to time events
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pushEvent(input int kind, input int ch, input int lo,
                           input int hi, input bit rel);
    exp_event_t e;
    e.kind = kind;
    e.ch   = ch;
    e.lo   = lo;
    e.hi   = hi;
    e.rel  = rel;
    sb.push_back(e);
  endtask

  // Drives the raw buttons and queues an edge event for every channel whose
  // new raw value differs from the level it should currently be debounced to.
  task automatic applyStimulus(input logic [1:0] raw);
    for (int ch = 0; ch < 2; ch++) begin
      if (raw[ch] != exp_level[ch]) begin
        pushEvent(raw[ch] ? KPRESS : KREL, ch, cyc + 32, cyc + 43, 1'b0);
      end
    end
    exp_level = raw;
    btn_raw   = raw;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic handleEvent(input int kind, input int ch);
    exp_event_t e;
    int base;
    logic in_win;
    if (sb.size() == 0) begin
      checkOutput($sformatf("unexpected_event_ch%0d_c%0d", ch, cyc), kind, 0);
    end else begin
      e = sb.pop_front();
      checkOutput($sformatf("event_kind_ch_c%0d", cyc), kind * 10 + ch, e.kind * 10 + e.ch);
      base   = e.rel ? last_press[ch] : 0;
      in_win = (cyc >= base + e.lo) && (cyc <= base + e.hi);
      checkOutput($sformatf("event_window_k%0d_ch%0d_c%0d_lo%0d_hi%0d", kind, ch, cyc,
                            base + e.lo, base + e.hi), in_win, 1);
    end
    if (kind == KPRESS) begin
      checkOutput($sformatf("level_at_press_ch%0d", ch), btn_level[ch], 1);
      last_press[ch] = cyc;
    end else if (kind == KREL) begin
      checkOutput($sformatf("level_at_release_ch%0d", ch), btn_level[ch], 0);
      checkOutput($sformatf("held_at_release_ch%0d", ch), btn_held[ch], 0);
      rel_prev_held[ch] = prev_held[ch];
    end else begin
      checkOutput($sformatf("held_at_long_ch%0d", ch), btn_held[ch], 1);
    end
  endtask

  // Monitor: every pulse seen on the falling edge is matched against the queue
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (btn_press[ch])   handleEvent(KPRESS, ch);
      if (btn_release[ch]) handleEvent(KREL, ch);
      if (btn_long[ch])    handleEvent(KLONG, ch);
    end
    prev_held = btn_held;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       bad;
    int         tick_seen;
    logic [19:0] tick_vec;

    reset_n    = 1'b0;
    turbosim   = 1'b1;
    btn_raw    = 2'b11;
    exp_level  = 2'b00;
    last_press[0] = 0;
    last_press[1] = 0;

    // Reset with both buttons held
    waitCycles(5);
    @(negedge clk);
    checkOutput("reset_outputs",
                {btn_level, btn_press, btn_release, btn_long, btn_held, tick}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(2'b11);
    @(negedge clk);
    checkOutput("first_cycle_outputs",
                {btn_level, btn_press, btn_release, btn_long, btn_held, tick}, 0);
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (btn_level != 2'b00) bad = 1'b1;
    end
    checkOutput("level_low_after_reset", bad, 0);
    waitCycles(15);
    checkOutput("level_both_after_reset", btn_level, 2'b11);
    checkOutput("simultaneous_press", last_press[0] - last_press[1], 0);
    checkOutput("sb_empty_reset", sb.size(), 0);
    applyStimulus(2'b00);
    waitCycles(60);
    checkOutput("level_both_released", btn_level, 2'b00);
    checkOutput("sb_empty_release_both", sb.size(), 0);

    // Bounce on channel 0, then a clean 60-cycle short press
    for (int k = 0; k < 14; k++) begin
      btn_raw[0] = ~btn_raw[0];
      waitCycles(15);
    end
    checkOutput("bounce_level", btn_level, 2'b00);
    checkOutput("sb_empty_bounce", sb.size(), 0);
    applyStimulus(2'b01);
    waitCycles(60);
    checkOutput("short_level", btn_level, 2'b01);
    applyStimulus(2'b00);
    waitCycles(60);
    checkOutput("short_held", btn_held, 2'b00);
    checkOutput("sb_empty_short", sb.size(), 0);

    // Long press on channel 1
    applyStimulus(2'b10);
    pushEvent(KLONG, 1, 70, 80, 1'b1);
    waitCycles(150);
    checkOutput("long_held_on", btn_held, 2'b10);
    applyStimulus(2'b00);
    waitCycles(30);
    checkOutput("held_until_release", btn_held, 2'b10);
    waitCycles(30);
    checkOutput("held_cleared", btn_held, 2'b00);
    checkOutput("held_fall_with_release", rel_prev_held[1], 1);
    checkOutput("sb_empty_long", sb.size(), 0);

    // Asynchronous reset while channel 1 is in the held state
    applyStimulus(2'b10);
    pushEvent(KLONG, 1, 70, 80, 1'b1);
    waitCycles(130);
    checkOutput("held_before_reset", btn_held, 2'b10);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_clear", {btn_level, btn_held, btn_press, btn_release, btn_long}, 0);
    exp_level = 2'b00;
    waitCycles(3);
    reset_n = 1'b1;
    applyStimulus(2'b10);
    waitCycles(60);
    checkOutput("repress_level", btn_level, 2'b10);
    applyStimulus(2'b00);
    waitCycles(60);
    checkOutput("sb_empty_async", sb.size(), 0);

    // Turbo switch part-way through a slow millisecond count
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    turbosim = 1'b0;
    waitCycles(2);
    reset_n = 1'b1;
    tick_seen = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (tick) tick_seen++;
    end
    checkOutput("no_tick_slow", tick_seen, 0);
    @(posedge clk);
    #1;
    turbosim = 1'b1;
    @(negedge clk);
    checkOutput("turbo_first_tick", tick, 1);
    tick_vec = '0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      tick_vec[j-1] = tick;
    end
    checkOutput("turbo_tick_period", tick_vec, 20'h80200);
    checkOutput("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel push-button conditioner that sits directly upstream of the `ct1` core's `buttons` input on the Cmod A7 build. Each raw button is synchronised into `clk`, debounced against a 1 ms time base, and turned into a clean level plus single-cycle press, release and long-press events. `turbosim` shrinks the time base so directed simulation runs in a few hundred cycles.

## Interface
- `NBTN`, 2: number of button channels.
- `CLK_PER_MS`, 100000: `clk` cycles per 1 ms tick when `turbosim`=0.
- `TURBO_CLKS`, 10: `clk` cycles per tick when `turbosim`=1.
- `DEB_MS`, 20: consecutive disagreeing ticks required to accept a new level, at least 1.
- `LONG_MS`, 1000: ticks of continuous stable-high level before the long-press event, at least 1.

- `clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `turbosim`  in  1  selects `TURBO_CLKS` instead of `CLK_PER_MS` as the tick period.
- `btn_raw`  in  NBTN  raw, asynchronous, bouncing buttons; 1 = pressed.
- `btn_level`  out  NBTN  debounced level.
- `btn_press`  out  NBTN  1-cycle pulse on a debounced 0→1 change.
- `btn_release`  out  NBTN  1-cycle pulse on a debounced 1→0 change.
- `btn_long`  out  NBTN  1-cycle pulse when the hold reaches `LONG_MS` ticks.
- `btn_held`  out  NBTN  level; high from `btn_long` until the debounced release.
- `tick`  out  1  1 ms (or turbo) strobe, exported for neighbouring timers.

## Operation
- **Reset.** Asynchronous on `reset_n`=0. All registers clear. Every output reads 0 while in reset and on the first cycle after release.
- **Prescaler.**
  - Free-running counter `pre`, width $clog2(CLK_PER_MS).
  - Terminal value T = `turbosim` ? `TURBO_CLKS` : `CLK_PER_MS`.
  - When `pre` ≥ T−1: `pre` ← 0 and `tick` = 1 for that cycle. Otherwise `pre` increments.
  - The ≥ compare makes a mid-count switch to turbo wrap on the next cycle; a switch back simply extends the count.
- **Synchroniser.** Two flops per channel, both reset to 0. `s` is the second-stage output.
- **Debounce, per channel.**
  - Registers: `deb_cnt` (width $clog2(DEB_MS+1)) and `stable`. `btn_level` = `stable`.
  - If `s` == `stable`: `deb_cnt` ← 0.
  - Else, on each `tick`: `deb_cnt` increments.
  - On the tick where `deb_cnt` reaches `DEB_MS`: `stable` ← `s` and `deb_cnt` ← 0.
  - Any single-cycle agreement between `s` and `stable` restarts the count, so bounce is rejected.
- **Edge events.**
  - `btn_press` and `btn_release` are registered and high for exactly the cycle in which `btn_level` first shows its new value.
  - Press and release can never both be high on the same channel.
- **Long press, per channel.**
  - `hold_cnt`, width $clog2(LONG_MS+1), clears whenever `stable`=0.
  - While `stable`=1 it increments on each `tick` and saturates at `LONG_MS`.
  - On the increment that reaches `LONG_MS`: `btn_long` pulses for one cycle and `btn_held` ← 1.
  - `btn_held` clears in the same cycle that `btn_release` pulses.
  - No repeat pulse until after a release.
- **Channel independence.** Channels are fully independent. Simultaneous presses produce simultaneous pulses. Channels share only `tick`.
- **Reset mid-operation.** A button held through reset is treated as a new press after release: `stable` restarts at 0 and needs a full debounce.

## Timing
- Synchroniser latency: 2 cycles.
- Debounce acceptance: between (`DEB_MS`−1)·T+3 and `DEB_MS`·T+3 cycles after a clean raw edge, depending on the prescaler phase.
- Long press: `btn_long` follows `btn_press` by between (`LONG_MS`−1)·T and `LONG_MS`·T cycles.
- Event pulses, `tick`: exactly 1 `clk` cycle wide.
- Minimum accepted pulse width: `DEB_MS`−1 full tick periods. Anything shorter is ignored.

## Test plan
Default configuration for all scenarios unless stated: `turbosim`=1, `TURBO_CLKS`=10, `DEB_MS`=4, `LONG_MS`=8.

1. **Reset.** Hold `reset_n`=0 with `btn_raw`=2'b11. → All outputs 0. After release, `btn_level` stays 0 for at least 32 cycles and reaches 2'b11 within 43 cycles, with `btn_press`=2'b11 for 1 cycle.
2. **Bounce rejection.** Drive `btn_raw[0]` toggling every 15 cycles for 200 cycles, then hold 1. → No `btn_press` during the toggling. Exactly one `btn_press[0]` pulse, 32–43 cycles after the final hold begins.
3. **Long press.** Hold `btn_raw[1]`=1 for 150 cycles. → `btn_press[1]` once. `btn_long[1]` 70–80 cycles after `btn_press[1]`, then `btn_held[1]`=1. On release: `btn_release[1]` and `btn_held[1]` falling in the same cycle.
4. **Short press.** Hold `btn_raw[0]`=1 for 60 cycles, then release. → Press and release pulses only. `btn_long` and `btn_held` stay 0.
5. **Turbo switch.** With `CLK_PER_MS`=100000, switch `turbosim` 0→1 while `pre`=5000. → `tick` the next cycle, then every 10 cycles.
6. **Async reset mid-hold.** Pulse `reset_n` low during a held `btn_held`=1. → `btn_held`, `btn_level` and `hold_cnt` clear immediately, with no release pulse. Re-debounce then gives a new `btn_press`.
